// File: rtl/pipe_cpu.sv
// pipe_cpu: five-stage (IF/ID/EX/MEM/WB) MIPS-subset pipeline with load-use and branch hazard handling.
// Define FORWARD_EN for EX operand forwarding; without it dependent instructions stall in ID instead.
module pipe_imem #(parameter int WORDS = 128) (
  input  logic [31:0] pc,
  output logic [31:0] instr
);
  localparam int AW = $clog2(WORDS);
  logic [31:0] Instr_Mem [0:WORDS-1];
  logic        unused_pc;
  assign unused_pc = ^pc[1:0];
  assign instr = (pc[31:2] < 30'(WORDS)) ? Instr_Mem[pc[AW+1:2]] : '0;
endmodule

module pipe_regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] Reg_File [0:31];
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) for (int i = 0; i < 32; i++) Reg_File[i] <= '0;
    else if (we && wa != 5'd0) Reg_File[wa] <= wd;
  // WB writes are visible to the same-cycle ID read
  assign rd1 = ra1 == 5'd0 ? '0 : (we && wa == ra1) ? wd : Reg_File[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : (we && wa == ra2) ? wd : Reg_File[ra2];
endmodule

module pipe_fwd (
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       exmem_rw,
  input  logic [4:0] exmem_rd,
  input  logic       memwb_rw,
  input  logic [4:0] memwb_rd,
  output logic [1:0] ForwardA,
  output logic [1:0] ForwardB
);
`ifdef FORWARD_EN
  assign ForwardA = (exmem_rw && exmem_rd != 5'd0 && exmem_rd == rs) ? 2'b10 :
                    (memwb_rw && memwb_rd != 5'd0 && memwb_rd == rs) ? 2'b01 : 2'b00;
  assign ForwardB = (exmem_rw && exmem_rd != 5'd0 && exmem_rd == rt) ? 2'b10 :
                    (memwb_rw && memwb_rd != 5'd0 && memwb_rd == rt) ? 2'b01 : 2'b00;
`else
  logic unused_fwd;
  assign unused_fwd = ^{rs, rt, exmem_rw, exmem_rd, memwb_rw, memwb_rd};
  assign ForwardA = 2'b00;
  assign ForwardB = 2'b00;
`endif
endmodule

module pipe_cpu #(
  parameter int IM_WORDS = 128,
  parameter int DM_WORDS = 128
) (
  input logic clk_i,
  input logic rst_i
);
  localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04;
  localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2, A_OR = 3'd3, A_SLT = 3'd4;
  localparam int DW = $clog2(DM_WORDS);
  typedef struct packed {
    logic rw, mr, mw, br, alu_src;
    logic [2:0] alu_op;
    logic [4:0] rs, rt, dst;
    logic [31:0] pc4, a, b, imm;
  } idex_t;
  typedef struct packed {
    logic rw, mr, mw;
    logic [4:0] dst;
    logic [31:0] alu, b;
  } exmem_t;
  typedef struct packed {
    logic rw, mr;
    logic [4:0] dst;
    logic [31:0] alu, rdata;
  } memwb_t;
  logic [31:0] pc, pc4, instr, ifid_instr, ifid_pc4;
  logic [31:0] rd1, rd2, wb_data, op_a, op_b, alu_b, alu_y, target, dmem_q;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [1:0]  fwd_a, fwd_b;
  logic        r_ok, uses_rt, lu_stall, dep_stall, stall, take, unused_bits;
  logic [31:0] dmem [0:DM_WORDS-1];
  idex_t  idex, id_d;
  exmem_t exmem;
  memwb_t memwb;
  assign pc4 = pc + 32'd4;
  pipe_imem #(.WORDS(IM_WORDS)) IM (.pc(pc), .instr(instr));
  assign op    = ifid_instr[31:26];
  assign rs    = ifid_instr[25:21];
  assign rt    = ifid_instr[20:16];
  assign rd    = ifid_instr[15:11];
  assign funct = ifid_instr[5:0];
  assign unused_bits = ^{ifid_instr[10:6], idex.imm[31:30]};
  assign r_ok = op == OP_R && (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                               funct == 6'h25 || funct == 6'h2A);
  pipe_regfile RF (
    .clk_i(clk_i), .rst_i(rst_i), .we(memwb.rw), .ra1(rs), .ra2(rt),
    .wa(memwb.dst), .wd(wb_data), .rd1(rd1), .rd2(rd2)
  );
  always_comb begin
    id_d         = '0;
    id_d.rw      = r_ok || op == OP_ADDI || op == OP_LW;
    id_d.mr      = op == OP_LW;
    id_d.mw      = op == OP_SW;
    id_d.br      = op == OP_BEQ;
    id_d.alu_src = op == OP_ADDI || op == OP_LW || op == OP_SW;
    id_d.alu_op  = op != OP_R ? A_ADD : funct == 6'h22 ? A_SUB : funct == 6'h24 ? A_AND :
                   funct == 6'h25 ? A_OR : funct == 6'h2A ? A_SLT : A_ADD;
    id_d.rs      = rs;
    id_d.rt      = rt;
    id_d.dst     = op == OP_R ? rd : rt;
    id_d.pc4     = ifid_pc4;
    id_d.a       = rd1;
    id_d.b       = rd2;
    id_d.imm     = {{16{ifid_instr[15]}}, ifid_instr[15:0]};
  end
  // rt is a source only for R-type, sw and beq; for addi/lw it is the destination
  assign uses_rt  = op == OP_R || op == OP_SW || op == OP_BEQ;
  assign lu_stall = idex.mr && (idex.dst == rs || (uses_rt && idex.dst == rt));
`ifdef FORWARD_EN
  assign dep_stall = 1'b0;
`else
  assign dep_stall = (idex.rw && idex.dst != 5'd0 && (idex.dst == rs || (uses_rt && idex.dst == rt))) ||
                     (exmem.rw && exmem.dst != 5'd0 && (exmem.dst == rs || (uses_rt && exmem.dst == rt)));
`endif
  assign stall = lu_stall || dep_stall;
  pipe_fwd FU (
    .rs(idex.rs), .rt(idex.rt), .exmem_rw(exmem.rw), .exmem_rd(exmem.dst),
    .memwb_rw(memwb.rw), .memwb_rd(memwb.dst), .ForwardA(fwd_a), .ForwardB(fwd_b)
  );
  assign wb_data = memwb.mr ? memwb.rdata : memwb.alu;
  assign op_a    = fwd_a == 2'b10 ? exmem.alu : fwd_a == 2'b01 ? wb_data : idex.a;
  assign op_b    = fwd_b == 2'b10 ? exmem.alu : fwd_b == 2'b01 ? wb_data : idex.b;
  assign alu_b   = idex.alu_src ? idex.imm : op_b;
  assign alu_y   = idex.alu_op == A_SUB ? op_a - alu_b :
                   idex.alu_op == A_AND ? op_a & alu_b :
                   idex.alu_op == A_OR  ? op_a | alu_b :
                   idex.alu_op == A_SLT ? {31'd0, $signed(op_a) < $signed(alu_b)} : op_a + alu_b;
  assign take    = idex.br && op_a == op_b;
  assign target  = idex.pc4 + {idex.imm[29:0], 2'b00};
  // a taken branch squashes IF/ID and ID/EX, overriding any stall
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      pc         <= '0;
      ifid_instr <= '0;
      ifid_pc4   <= '0;
      idex       <= '0;
      exmem      <= '0;
      memwb      <= '0;
    end else begin
      pc         <= take ? target : stall ? pc : pc4;
      ifid_instr <= take ? '0 : stall ? ifid_instr : instr;
      ifid_pc4   <= take ? '0 : stall ? ifid_pc4 : pc4;
      idex       <= (take || stall) ? '0 : id_d;
      exmem      <= '{rw: idex.rw, mr: idex.mr, mw: idex.mw, dst: idex.dst, alu: alu_y, b: op_b};
      memwb      <= '{rw: exmem.rw, mr: exmem.mr, dst: exmem.dst, alu: exmem.alu, rdata: dmem_q};
    end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) for (int i = 0; i < DM_WORDS; i++) dmem[i] <= '0;
    else if (exmem.mw) dmem[exmem.alu[DW+1:2]] <= exmem.b;
  assign dmem_q = dmem[exmem.alu[DW+1:2]];
endmodule

// File: tb/tb_pipe_cpu.sv
// tb_pipe_cpu: directed programs for pipe_cpu, checking register results, PC stepping, forwarding and stalls.
module tb_pipe_cpu;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int          prog;
    int          r;
    logic [31:0] exp;
  } vec_t;
  vec_t        vecs[$];
  logic [31:0] progs [0:4][0:7];
  int          holds;
  logic [1:0]  fa_sub;
  logic [1:0]  any_fwd;

  pipe_cpu dut (.clk_i(clk_i), .rst_i(rst_i));

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] r_ins(input int s, input int t, input int d, input logic [5:0] f);
    return {6'h00, 5'(s), 5'(t), 5'(d), 5'd0, f};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int s, input int t, input int imm);
    return {op, 5'(s), 5'(t), 16'(imm)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  task automatic run_prog(input int p, input int ncyc);
    logic [31:0] prev;
    rst_i = 1'b0;
    for (int i = 0; i < 128; i++) dut.IM.Instr_Mem[i] = (i < 8) ? progs[p][i] : 32'd0;
    holds   = 0;
    fa_sub  = 2'b00;
    any_fwd = 2'b00;
    @(negedge clk_i);
    chk($sformatf("p%0d_reset_pc", p), dut.pc, 32'd0);
    rst_i = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      prev = dut.pc;
      @(posedge clk_i);
      #1;
      if (dut.pc == prev) holds++;
      if (p == 0) chk($sformatf("p0_pc_step%0d", c), dut.pc, prev + 32'd4);
      if (c == 5) fa_sub = dut.FU.ForwardA;
      any_fwd = any_fwd | dut.FU.ForwardA | dut.FU.ForwardB;
    end
  endtask

  initial begin
    for (int p = 0; p < 5; p++) for (int i = 0; i < 8; i++) progs[p][i] = 32'd0;
    progs[1][0] = i_ins(6'h08, 0, 1, 3);
    progs[1][1] = i_ins(6'h08, 0, 2, 4);
    progs[1][2] = r_ins(1, 2, 3, 6'h20);
    progs[1][3] = r_ins(3, 1, 4, 6'h22);
    progs[1][4] = r_ins(3, 2, 5, 6'h24);
    progs[1][5] = r_ins(4, 5, 6, 6'h25);
    progs[1][6] = r_ins(1, 2, 7, 6'h2A);
    progs[2][0] = i_ins(6'h08, 0, 1, 9);
    progs[2][1] = i_ins(6'h2B, 0, 1, 8);
    progs[2][2] = i_ins(6'h23, 0, 2, 8);
    progs[2][3] = r_ins(2, 2, 3, 6'h20);
    progs[3][0] = i_ins(6'h08, 0, 1, 1);
    progs[3][1] = i_ins(6'h04, 1, 1, 2);
    progs[3][2] = i_ins(6'h08, 0, 2, 5);
    progs[3][3] = i_ins(6'h08, 0, 3, 6);
    progs[3][4] = i_ins(6'h08, 0, 4, 7);
    progs[4][0] = i_ins(6'h08, 0, 1, 1);
    progs[4][1] = i_ins(6'h04, 0, 1, 5);
    progs[4][2] = i_ins(6'h08, 0, 0, 5);
    progs[4][3] = i_ins(6'h08, 0, 2, -1);
    vecs.push_back('{1, 1, 32'd3});
    vecs.push_back('{1, 2, 32'd4});
    vecs.push_back('{1, 3, 32'd7});
    vecs.push_back('{1, 4, 32'd4});
    vecs.push_back('{1, 5, 32'd4});
    vecs.push_back('{1, 6, 32'd4});
    vecs.push_back('{1, 7, 32'd1});
    vecs.push_back('{2, 1, 32'd9});
    vecs.push_back('{2, 2, 32'd9});
    vecs.push_back('{2, 3, 32'd18});
    vecs.push_back('{3, 1, 32'd1});
    vecs.push_back('{3, 2, 32'd0});
    vecs.push_back('{3, 3, 32'd0});
    vecs.push_back('{3, 4, 32'd7});
    vecs.push_back('{4, 0, 32'd0});
    vecs.push_back('{4, 1, 32'd1});
    vecs.push_back('{4, 2, 32'hFFFF_FFFF});

    run_prog(0, 100);
    for (int r = 0; r < 32; r++) chk($sformatf("p0_r%0d", r), dut.RF.Reg_File[r], 32'd0);
    chk("p0_pc_final", dut.pc, 32'd400);

    for (int p = 1; p <= 4; p++) begin
      run_prog(p, 40);
      foreach (vecs[k])
        if (vecs[k].prog == p)
          chk($sformatf("p%0d_r%0d", p, vecs[k].r), dut.RF.Reg_File[vecs[k].r], vecs[k].exp);
      if (p == 1) begin
`ifdef FORWARD_EN
        chk("p1_fwdA_sub_in_ex", 32'(fa_sub), 32'd2);
`else
        chk("p1_fwd_always_zero", 32'(any_fwd), 32'd0);
`endif
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        chk("async_reset_pc", dut.pc, 32'd0);
        chk("async_reset_r3", dut.RF.Reg_File[3], 32'd0);
      end
      if (p == 2) begin
`ifdef FORWARD_EN
        chk("p2_load_use_bubbles", 32'(holds), 32'd1);
`else
        chk("p2_stall_cycles", 32'(holds), 32'd4);
`endif
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
